// File: rtl/aes_key_expand128.sv
// Iterative AES-128 key expansion: emits round keys 0..10 over a valid/ready stream.
// Define AES_KEYEXP_FOUR_SBOX_EN to substitute all four RotWord bytes in a single cycle.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the most significant byte of the table.
  assign d = SBOX[11'd2047 - {a, 3'b000} -: 8];

endmodule

module aes_key_expand128 (
  input  logic         mclk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, OUT, SUB, CALC} state_t;

  state_t        r_state;
  logic [127:0]  r_key;
  logic [3:0]    r_round;
  logic [31:0]   r_subWord;
  logic          r_busy;
  logic          r_valid;
  logic          r_done;

  logic [31:0]   w_w0, w_w1, w_w2, w_w3;
  logic [31:0]   w_rot;
  logic [3:0]    w_nextRound;
  logic [7:0]    w_rcon;
  logic [31:0]   w_n0, w_n1, w_n2, w_n3;

  function automatic logic [7:0] rconFor(input logic [3:0] round);
    case (round)
      4'd1:    rconFor = 8'h01;
      4'd2:    rconFor = 8'h02;
      4'd3:    rconFor = 8'h04;
      4'd4:    rconFor = 8'h08;
      4'd5:    rconFor = 8'h10;
      4'd6:    rconFor = 8'h20;
      4'd7:    rconFor = 8'h40;
      4'd8:    rconFor = 8'h80;
      4'd9:    rconFor = 8'h1b;
      4'd10:   rconFor = 8'h36;
      default: rconFor = 8'h00;
    endcase
  endfunction

  assign w_w0        = r_key[127:96];
  assign w_w1        = r_key[95:64];
  assign w_w2        = r_key[63:32];
  assign w_w3        = r_key[31:0];
  assign w_rot       = {w_w3[23:0], w_w3[31:24]};
  assign w_nextRound = r_round + 4'd1;
  assign w_rcon      = rconFor(w_nextRound);
  assign w_n0        = w_w0 ^ r_subWord ^ {w_rcon, 24'h0};
  assign w_n1        = w_w1 ^ w_n0;
  assign w_n2        = w_w2 ^ w_n1;
  assign w_n3        = w_w3 ^ w_n2;

`ifdef AES_KEYEXP_FOUR_SBOX_EN
  logic [31:0] w_sboxOut;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (w_rot[8*g +: 8]),
      .d (w_sboxOut[8*g +: 8])
    );
  end
`else
  logic [1:0]  r_cnt;
  logic [4:0]  w_bytePos;
  logic [7:0]  w_sboxOut;

  // Byte 0 is the most significant byte of RotWord, so the bit position counts down.
  assign w_bytePos = {~r_cnt, 3'b000};

  aes_sbox u_sbox (
    .a (w_rot[w_bytePos +: 8]),
    .d (w_sboxOut)
  );
`endif

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_key     <= '0;
      r_round   <= '0;
      r_subWord <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
`ifndef AES_KEYEXP_FOUR_SBOX_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // A start arriving alongside the done pulse belongs to the finished run and is dropped.
        IDLE: begin
          if (start && !r_done) begin
            r_key   <= key_in;
            r_round <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= OUT;
          end
        end
        OUT: begin
          if (rk_ready) begin
            r_valid <= 1'b0;
            if (r_round == 4'd10) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
`ifndef AES_KEYEXP_FOUR_SBOX_EN
              r_cnt   <= '0;
`endif
              r_state <= SUB;
            end
          end
        end
        SUB: begin
`ifdef AES_KEYEXP_FOUR_SBOX_EN
          r_subWord <= w_sboxOut;
          r_state   <= CALC;
`else
          r_subWord[w_bytePos +: 8] <= w_sboxOut;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= CALC;
          end
`endif
        end
        CALC: begin
          r_key   <= {w_n0, w_n1, w_n2, w_n3};
          r_round <= w_nextRound;
          r_valid <= 1'b1;
          r_state <= OUT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign rk_valid = r_valid;
  assign rk_data  = r_key;
  assign rk_round = r_round;
  assign done     = r_done;

endmodule

// File: tb/tb_aes_key_expand128.sv
// Directed bench for aes_key_expand128: FIPS-197 and all-zero keys, stall, stray start, mid-run reset.

module tb_aes_key_expand128;

`ifdef AES_KEYEXP_FOUR_SBOX_EN
  localparam int LAT   = 2;
  localparam int TOTAL = 31;
`else
  localparam int LAT   = 5;
  localparam int TOTAL = 61;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         mclk     = 1'b0;
  logic         reset_n  = 1'b1;
  logic         start    = 1'b0;
  logic [127:0] key_in   = '0;
  logic         rk_ready = 1'b0;
  logic         busy;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         done;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [127:0] expTab [0:10];
  logic [10:0]  expMask;
  int           obsCyc [0:10];
  int           nRounds;
  int           doneCount;

  aes_key_expand128 dut (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .done     (done)
  );

  always #5 mclk = ~mclk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic loadFips();
    expTab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expTab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    expTab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    expTab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    expTab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    expTab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    expTab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    expTab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    expTab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    expTab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    expTab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    expMask    = '1;
  endtask

  task automatic loadZero();
    for (int i = 0; i <= 10; i++) expTab[i] = '0;
    expTab[1]  = 128'h62636363626363636263636362636363;
    expTab[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    expMask    = 11'b100_0000_0011;
  endtask

  // Runs one expansion; optional stall at stallRound, stray start at pokeRound,
  // and a reset pulled during the SUB phase that builds abortRound.
  task automatic applyStimulus(input logic [127:0] key, input int stallRound,
                               input int pokeRound, input int abortRound);
    int cyc       = 0;
    int stallLeft = 7;
    int tail      = 0;
    bit aborting  = 1'b0;
    bit finished  = 1'b0;
    nRounds   = 0;
    doneCount = 0;
    @(negedge mclk);
    start    = 1'b1;
    key_in   = key;
    rk_ready = 1'b1;
    @(negedge mclk);
    cyc    = 1;
    start  = 1'b0;
    key_in = '0;
    while (!finished && cyc < 400) begin
      if (done) doneCount++;
      if (aborting) begin
        checkOutput("inSub", {busy, rk_valid}, 2'b10);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abortData", rk_data, '0);
        checkOutput("abortFlags", {busy, rk_valid, done, rk_round}, '0);
        finished = 1'b1;
      end else if (nRounds == 11) begin
        tail++;
        if (tail == 1) begin
          checkOutput("donePulse", done, 1'b1);
          checkOutput("idleBusy", busy, 1'b0);
        end
        if (tail == 3) finished = 1'b1;
      end else if (rk_valid) begin
        if (rk_round == stallRound && stallLeft > 0) begin
          checkOutput("stallRound", rk_round, stallRound);
          checkOutput("stallData", rk_data, expTab[stallRound]);
          rk_ready = 1'b0;
          stallLeft--;
        end else begin
          rk_ready = 1'b1;
          checkOutput($sformatf("round%0d", nRounds), rk_round, nRounds);
          if (expMask[nRounds]) checkOutput($sformatf("key%0d", nRounds), rk_data, expTab[nRounds]);
          obsCyc[nRounds] = cyc;
          if (nRounds == pokeRound) begin
            start  = 1'b1;
            key_in = '1;
          end
          if (nRounds == abortRound - 1) aborting = 1'b1;
          nRounds++;
        end
      end
      if (!finished) begin
        @(negedge mclk);
        cyc++;
        start  = 1'b0;
        key_in = '0;
      end
    end
    if (!finished) checkOutput("timeout", nRounds, 11);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    checkOutput("resetData", rk_data, '0);
    checkOutput("resetFlags", {busy, rk_valid, done, rk_round}, '0);
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;

    loadFips();
    applyStimulus(FIPS_KEY, -1, -1, -1);
    checkOutput("fipsDone", doneCount, 1);
    checkOutput("latency", obsCyc[1] - obsCyc[0] - 1, LAT);
    checkOutput("totalCycles", obsCyc[10], TOTAL);

    loadZero();
    applyStimulus('0, -1, -1, -1);
    checkOutput("zeroDone", doneCount, 1);

    loadFips();
    applyStimulus(FIPS_KEY, 3, -1, -1);
    checkOutput("stallRounds", nRounds, 11);
    checkOutput("stallDone", doneCount, 1);

    applyStimulus(FIPS_KEY, -1, 5, -1);
    checkOutput("pokeDone", doneCount, 1);

    applyStimulus(FIPS_KEY, -1, -1, 6);
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;

    loadZero();
    applyStimulus('0, -1, -1, -1);
    checkOutput("restartRounds", nRounds, 11);
    checkOutput("restartDone", doneCount, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
